// File: rtl/xy_seq_gen.sv
// Pattern-driven X/Y symbol generator with Z-hit counting for exercising a receiving FSM.
// Build option: define XY_SEQ_GEN_LOOP_EN to let LOOP repeat the pattern until ABORT.
module xy_seq_gen #(
  parameter int AW = 4,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WE,
  input  logic [AW-1:0] WADDR,
  input  logic [1:0]    WDATA,
  input  logic [AW-1:0] LEN,
  input  logic          START,
  input  logic          ABORT,
  input  logic          LOOP,
  input  logic          Z,
  output logic          X,
  output logic          Y,
  output logic          BUSY,
  output logic          DONE,
  output logic [CW-1:0] ZCNT
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state_q;
  logic [1:0]    mem_q [2**AW];
  logic [AW-1:0] idx_q, len_q;
  logic          loop_q;
  logic [1:0]    xy_q;
  logic          busy_q, done_q;
  logic [CW-1:0] zcnt_q;

  logic [AW-1:0] idx_d;
  logic [1:0]    sym0_d;
  logic          loop_d;
  logic [CW-1:0] zcnt_d;

`ifdef XY_SEQ_GEN_LOOP_EN
  assign loop_d = LOOP;
`else
  // Port kept for a stable interface; looping is compiled out.
  assign loop_d = LOOP & 1'b0;
`endif

  // A write landing on address 0 alongside START is forwarded as the first symbol.
  assign sym0_d = (WE && WADDR == '0) ? WDATA : mem_q[0];
  assign idx_d  = (idx_q == len_q) ? '0 : idx_q + AW'(1);
  assign zcnt_d = (busy_q && Z && zcnt_q != '1) ? zcnt_q + CW'(1) : zcnt_q;

  // Pattern memory has no reset so contents survive RST.
  always_ff @(posedge CLK) begin
    if (!RST && WE && state_q == IDLE) mem_q[WADDR] <= WDATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      xy_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zcnt_q  <= '0;
    end else begin
      zcnt_q <= zcnt_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (START) begin
          state_q <= RUN;
          len_q   <= LEN;
          loop_q  <= loop_d;
          idx_q   <= '0;
          xy_q    <= sym0_d;
          busy_q  <= 1'b1;
          zcnt_q  <= '0;
        end
        RUN: begin
          if (ABORT) begin
            state_q <= IDLE;
            xy_q    <= '0;
            busy_q  <= 1'b0;
          end else if (idx_q == len_q && !loop_q) begin
            state_q <= FIN;
            xy_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_d;
            xy_q  <= mem_q[idx_d];
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign X    = xy_q[1];
  assign Y    = xy_q[0];
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ZCNT = zcnt_q;

endmodule

// File: tb/tb_xy_seq_gen.sv
// Directed/random bench for xy_seq_gen; expected streams come from a shadow pattern array.
module tb_xy_seq_gen;
  localparam int AW = 4;
  localparam int CW = 4;
`ifdef XY_SEQ_GEN_LOOP_EN
  localparam bit LOOP_BUILD = 1'b1;
`else
  localparam bit LOOP_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          RST, WE, START, ABORT, LOOP, Z;
  logic [AW-1:0] WADDR, LEN;
  logic [1:0]    WDATA;
  logic          X, Y, BUSY, DONE;
  logic [CW-1:0] ZCNT;

  always #5 clk = ~clk;

  xy_seq_gen #(.AW(AW), .CW(CW)) dut (
    .CLK(clk), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .LEN(LEN),
    .START(START), .ABORT(ABORT), .LOOP(LOOP), .Z(Z),
    .X(X), .Y(Y), .BUSY(BUSY), .DONE(DONE), .ZCNT(ZCNT)
  );

  logic [1:0] mmem [2**AW];
  int n_assert = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] exp);
    n_assert++;
    assert ({X, Y, BUSY, DONE} === exp) else begin
      n_fail++;
      $error("FAIL %s: observed XYBD=%b expected %b", tag, {X, Y, BUSY, DONE}, exp);
    end
  endtask

  task automatic chk_z(input string tag, input int hits);
    logic [CW-1:0] e;
    e = CW'((hits > (1 << CW) - 1) ? (1 << CW) - 1 : hits);
    n_assert++;
    assert (ZCNT === e) else begin
      n_fail++;
      $error("FAIL %s/zcnt: observed %0d expected %0d", tag, ZCNT, e);
    end
  endtask

  task automatic wr(input int addr, input logic [1:0] data);
    WE = 1'b1; WADDR = AW'(addr); WDATA = data;
    tick();
    WE = 1'b0;
    mmem[addr] = data;
  endtask

  task automatic fill_rand();
    for (int a = 0; a < 2**AW; a++) wr(a, 2'($urandom));
  endtask

  // One run: symbols 0..len (cycled when looping is effective), then DONE or ABORT.
  // zmode: 0 = Z low, 1 = Z high, 2 = random Z per cycle.
  task automatic run(input string tag, input int len, input bit lp, input int max_sym,
                     input int zmode, input bit we_mid);
    bit eff;
    int n, zacc;
    eff  = lp && LOOP_BUILD;
    n    = eff ? max_sym : len + 1;
    zacc = 0;
    LEN = AW'(len); LOOP = lp; START = 1'b1;
    tick();
    START = 1'b0; LOOP = 1'b0; WE = 1'b0; ABORT = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk_out(tag, {mmem[i % (len + 1)], 2'b10});
      chk_z(tag, zacc);
      WE = 1'b0;
      Z = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      zacc += int'(Z);
      if (we_mid && i == 0) begin
        WE = 1'b1; WADDR = AW'(2); WDATA = ~mmem[2];
      end
      if (eff && i == n - 1) ABORT = 1'b1;
      tick();
    end
    WE = 1'b0; ABORT = 1'b0; Z = 1'b0;
    if (eff) begin
      chk_out({tag, "/abort"}, 4'b0000);
      chk_z({tag, "/abort"}, zacc);
      tick();
      chk_out({tag, "/nodone"}, 4'b0000);
    end else begin
      chk_out({tag, "/done"}, 4'b0001);
      chk_z({tag, "/done"}, zacc);
      tick();
      chk_out({tag, "/idle"}, 4'b0000);
      chk_z({tag, "/hold"}, zacc);
    end
  endtask

  initial begin
    RST = 1'b1; WE = 1'b0; START = 1'b0; ABORT = 1'b0; LOOP = 1'b0; Z = 1'b0;
    WADDR = '0; LEN = '0; WDATA = '0;
    tick();
    tick();
    chk_out("reset", 4'b0000);
    chk_z("reset", 0);
    RST = 1'b0;

    // Fixed pattern 11,00,00,11
    wr(0, 2'b11); wr(1, 2'b00); wr(2, 2'b00); wr(3, 2'b11);
    run("basic", 3, 1'b0, 0, 0, 1'b0);

    fill_rand();
    for (int k = 0; k < 3; k++) run("rand", $urandom_range(0, 15), 1'b0, 0, 2, 1'b0);
    run("len0", 0, 1'b0, 0, 1, 1'b0);
    run("len0_loop", 0, 1'b1, 5, 1, 1'b0);
    run("loop2", 1, 1'b1, 7, 2, 1'b0);

    // Z saturation over a full-depth run, then cleared by the next START
    fill_rand();
    run("zsat", 15, 1'b0, 0, 1, 1'b0);
    run("zclr", 2, 1'b0, 0, 0, 1'b0);

    // Write-through forwarding on START; ABORT in IDLE ignored; mid-run write dropped
    WE = 1'b1; WADDR = '0; WDATA = 2'b10; ABORT = 1'b1;
    mmem[0] = 2'b10;
    run("fwd", 3, 1'b0, 0, 0, 1'b1);

    // Abort in a non-looping run: idle next cycle, no DONE afterwards
    LEN = AW'(9); START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    chk_out("pre_abort", {mmem[1], 2'b10});
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk_out("abort", 4'b0000);
    tick();
    chk_out("abort/nodone", 4'b0000);

    // Reset mid-run, then memory must be intact
    LEN = AW'(7); START = 1'b1; Z = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    chk_out("pre_rst", {mmem[2], 2'b10});
    chk_z("pre_rst", 2);
    RST = 1'b1;
    tick();
    RST = 1'b0; Z = 1'b0;
    chk_out("rst_mid", 4'b0000);
    chk_z("rst_mid", 0);
    tick();
    chk_out("rst_idle", 4'b0000);
    run("after_rst", 7, 1'b0, 0, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
